// File: rtl/lsu_bus_if.sv
// rtl/lsu_bus_if.sv - MEM-stage load/store unit driving a valid/grant/rvalid data bus
module lsu_bus_if #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_mode_i,
  output logic        stall_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  state_t      r_state, w_next;
  logic [7:0]  r_cnt;
  logic [2:0]  r_mode;
  logic [1:0]  r_off;
  logic        r_rsp_valid, r_misalign, r_err, r_bus_req, r_bus_we;
  logic [31:0] r_rdata, r_bus_addr, r_bus_wdata;
  logic [3:0]  r_bus_be;

  logic        w_illegal, w_misalign, w_timeout;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_load;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Illegal modes take priority so a bogus mode never reports as misaligned.
  always_comb begin
    w_illegal  = (req_mode_i == 3'b011) || (req_mode_i[2:1] == 2'b11) ||
                 (req_we_i && req_mode_i[2]);
    w_misalign = !w_illegal &&
                 (((req_mode_i[1:0] == 2'b01) && req_addr_i[0]) ||
                  ((req_mode_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00)));
    case (req_mode_i[1:0])
      2'b00: begin
        w_be    = 4'b0001 << req_addr_i[1:0];
        w_wdata = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << req_addr_i[1:0];
        w_wdata = {2{req_wdata_i[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = req_wdata_i;
      end
    endcase
  end

  always_comb begin
    w_byte = bus_rdata_i[{r_off, 3'b000} +: 8];
    w_half = r_off[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    case (r_mode)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = bus_rdata_i;
    endcase
  end

  assign w_timeout = (r_cnt == LP_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (req_valid_i) w_next = (w_illegal || w_misalign) ? S_DONE : S_REQ;
      S_REQ:  if (w_timeout) w_next = S_DONE;
              else if (bus_gnt_i) w_next = S_WAIT;
      S_WAIT: if (bus_rvalid_i || w_timeout) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_misalign  <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= 32'd0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'd0;
      r_bus_be    <= 4'd0;
      r_bus_wdata <= 32'd0;
      r_cnt       <= 8'd0;
      r_mode      <= 3'd0;
      r_off       <= 2'd0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_misalign  <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        S_IDLE: if (req_valid_i) begin
          if (w_illegal || w_misalign) begin
            r_rsp_valid <= 1'b1;
            r_err       <= w_illegal;
            r_misalign  <= w_misalign;
            r_rdata     <= 32'd0;
          end else begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= req_we_i;
            r_bus_addr  <= {req_addr_i[31:2], 2'b00};
            r_bus_be    <= w_be;
            r_bus_wdata <= w_wdata;
            r_mode      <= req_mode_i;
            r_off       <= req_addr_i[1:0];
            r_cnt       <= 8'd0;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 8'd1;
          if (w_timeout) begin
            r_bus_req   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_err       <= 1'b1;
            r_rdata     <= 32'd0;
          end else if (bus_gnt_i) begin
            r_bus_req <= 1'b0;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          if (bus_rvalid_i) begin
            r_rsp_valid <= 1'b1;
            r_err       <= bus_err_i;
            r_rdata     <= (bus_err_i || r_bus_we) ? 32'd0 : w_load;
          end else if (w_timeout) begin
            r_rsp_valid <= 1'b1;
            r_err       <= 1'b1;
            r_rdata     <= 32'd0;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall_o     = req_valid_i && (r_state != S_DONE);
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rdata;
  assign misalign_o  = r_misalign;
  assign bus_err_o   = r_err;
  assign bus_req_o   = r_bus_req;
  assign bus_we_o    = r_bus_we;
  assign bus_addr_o  = r_bus_addr;
  assign bus_be_o    = r_bus_be;
  assign bus_wdata_o = r_bus_wdata;

endmodule

// File: tb/tb_lsu_bus_if.sv
// tb/tb_lsu_bus_if.sv - scoreboard bench for lsu_bus_if
module tb_lsu_bus_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_i = 1'b0, req_we_i = 1'b0;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0;
  logic [2:0]  req_mode_i = '0;
  logic        stall_o, rsp_valid_o, misalign_o, bus_err_o;
  logic [31:0] rsp_rdata_o;
  logic        bus_req_o, bus_we_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_be_o;
  logic        bus_gnt_i = 1'b0, bus_rvalid_i = 1'b0, bus_err_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;

  lsu_bus_if #(.TIMEOUT(255)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_mode_i(req_mode_i),
    .stall_o(stall_o), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i), .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        mis;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t obs_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int          o_lat, o_stall, o_req_cycles;
  logic [3:0]  o_be;
  logic [31:0] o_addr, o_wdata;
  logic        o_we, o_req_at_done, o_after_valid;

  // Drives one request and a bus slave; gnt_dly < 0 means never grant.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] mode, input int gnt_dly,
                         input logic [31:0] rd, input logic berr);
    int  since, waited;
    bit  granted;
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr;
    req_wdata_i = wdata; req_mode_i = mode;
    o_lat = -1; o_stall = 0; o_req_cycles = 0; o_req_at_done = 1'b0;
    o_be = '0; o_addr = '0; o_wdata = '0; o_we = 1'b0;
    granted = 0; since = 0; waited = 0;
    for (int i = 0; i < 400; i++) begin
      bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
      if (granted) begin
        since++;
        if (since == 1) begin
          bus_rvalid_i = 1'b1; bus_rdata_i = rd; bus_err_i = berr;
        end
      end else if (bus_req_o) begin
        if (gnt_dly >= 0 && waited >= gnt_dly) begin
          bus_gnt_i = 1'b1; granted = 1;
        end
        waited++;
      end
      @(negedge clk);
      if (stall_o) o_stall++;
      if (bus_req_o) begin
        o_req_cycles++;
        o_be = bus_be_o; o_addr = bus_addr_o; o_wdata = bus_wdata_o; o_we = bus_we_o;
      end
      if (rsp_valid_o) begin
        o_lat = i; o_req_at_done = bus_req_o;
        obs_q.push_back('{rsp_rdata_o, misalign_o, bus_err_o});
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_err_i = 1'b0;
    @(negedge clk);
    o_after_valid = rsp_valid_o;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({rsp_valid_o, misalign_o, bus_err_o, bus_req_o, bus_we_o, stall_o} !== 6'b0 ||
        rsp_rdata_o !== 32'd0 || bus_addr_o !== 32'd0 || bus_be_o !== 4'd0 || bus_wdata_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: flags=%b rdata=%h addr=%h be=%b wdata=%h, required all zero",
               {rsp_valid_o, misalign_o, bus_err_o, bus_req_o, bus_we_o, stall_o},
               rsp_rdata_o, bus_addr_o, bus_be_o, bus_wdata_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_loads;
    rsp_t e, o;
    exp_q.push_back('{32'hDEADBEEF, 1'b0, 1'b0});
    run_txn(1'b0, 32'h100, 32'h0, 3'b010, 0, 32'hDEADBEEF, 1'b0);
    n_tests++;
    if (o_lat !== 3) begin n_fail++; $display("FAIL lw_latency: got %0d, required 3", o_lat); end
    n_tests++;
    if (o_stall !== 3) begin n_fail++; $display("FAIL lw_stall: got %0d, required 3", o_stall); end
    n_tests++;
    if (o_be !== 4'b1111 || o_addr !== 32'h100 || o_we !== 1'b0) begin
      n_fail++; $display("FAIL lw_bus: be=%b addr=%h we=%b, required 1111 00000100 0", o_be, o_addr, o_we);
    end
    n_tests++;
    if (o_after_valid !== 1'b0) begin n_fail++; $display("FAIL lw_pulse: rsp_valid=%b after DONE, required 0", o_after_valid); end
    exp_q.push_back('{32'hFFFFFF80, 1'b0, 1'b0});
    run_txn(1'b0, 32'h103, 32'h0, 3'b000, 0, 32'h80123456, 1'b0);
    n_tests++;
    if (o_be !== 4'b1000) begin n_fail++; $display("FAIL lb_be: got %b, required 1000", o_be); end
    exp_q.push_back('{32'h00000080, 1'b0, 1'b0});
    run_txn(1'b0, 32'h103, 32'h0, 3'b100, 1, 32'h80123456, 1'b0);
    exp_q.push_back('{32'h0000BEEF, 1'b0, 1'b0});
    run_txn(1'b0, 32'h102, 32'h0, 3'b101, 0, 32'hBEEF1234, 1'b0);
    exp_q.push_back('{32'hFFFFBEEF, 1'b0, 1'b0});
    run_txn(1'b0, 32'h102, 32'h0, 3'b001, 0, 32'hBEEF1234, 1'b0);
    exp_q.push_back('{32'h0000007F, 1'b0, 1'b0});
    run_txn(1'b0, 32'h100, 32'h0, 3'b000, 2, 32'hAAAAAA7F, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL load_rsp: no response, required %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL load_rsp: got rdata=%h mis=%b err=%b, required rdata=%h mis=%b err=%b",
                                              o.rdata, o.mis, o.err, e.rdata, e.mis, e.err); end
      end
    end
  endtask

  task automatic test_stores;
    rsp_t e, o;
    exp_q.push_back('{32'h0, 1'b0, 1'b0});
    run_txn(1'b1, 32'h101, 32'h000000AB, 3'b000, 2, 32'hFFFFFFFF, 1'b0);
    n_tests++;
    if (o_be !== 4'b0010 || o_wdata !== 32'hABABABAB || o_we !== 1'b1 || o_addr !== 32'h100) begin
      n_fail++; $display("FAIL sb_bus: be=%b wdata=%h we=%b addr=%h, required 0010 ababab ab 1 00000100", o_be, o_wdata, o_we, o_addr);
    end
    n_tests++;
    if (o_req_cycles !== 3 || o_lat !== 5) begin
      n_fail++; $display("FAIL sb_timing: req_cycles=%0d lat=%0d, required 3 5", o_req_cycles, o_lat);
    end
    exp_q.push_back('{32'h0, 1'b0, 1'b0});
    run_txn(1'b1, 32'h102, 32'h00001234, 3'b001, 0, 32'h0, 1'b0);
    n_tests++;
    if (o_be !== 4'b1100 || o_wdata !== 32'h12341234) begin
      n_fail++; $display("FAIL sh_bus: be=%b wdata=%h, required 1100 12341234", o_be, o_wdata);
    end
    exp_q.push_back('{32'h0, 1'b0, 1'b0});
    run_txn(1'b1, 32'h104, 32'hCAFEF00D, 3'b010, 0, 32'h0, 1'b0);
    n_tests++;
    if (o_be !== 4'b1111 || o_wdata !== 32'hCAFEF00D || o_addr !== 32'h104) begin
      n_fail++; $display("FAIL sw_bus: be=%b wdata=%h addr=%h, required 1111 cafef00d 00000104", o_be, o_wdata, o_addr);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL store_rsp: no response, required %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL store_rsp: got rdata=%h mis=%b err=%b, required rdata=%h mis=%b err=%b",
                                              o.rdata, o.mis, o.err, e.rdata, e.mis, e.err); end
      end
    end
  endtask

  task automatic test_misalign_illegal;
    rsp_t e, o;
    logic [31:0] addrs[4] = '{32'h102, 32'h101, 32'h100, 32'h100};
    logic [2:0]  modes[4] = '{3'b010, 3'b001, 3'b011, 3'b100};
    logic        wes[4]   = '{1'b0, 1'b0, 1'b0, 1'b1};
    exp_q.push_back('{32'h0, 1'b1, 1'b0});
    exp_q.push_back('{32'h0, 1'b1, 1'b0});
    exp_q.push_back('{32'h0, 1'b0, 1'b1});
    exp_q.push_back('{32'h0, 1'b0, 1'b1});
    for (int k = 0; k < 4; k++) begin
      run_txn(wes[k], addrs[k], 32'h55, modes[k], 0, 32'hFFFFFFFF, 1'b0);
      n_tests++;
      if (o_lat !== 1 || o_req_cycles !== 0) begin
        n_fail++; $display("FAIL reject_%0d: lat=%0d bus_req_cycles=%0d, required 1 0", k, o_lat, o_req_cycles);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL reject_rsp: no response, required %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL reject_rsp: got rdata=%h mis=%b err=%b, required rdata=%h mis=%b err=%b",
                                              o.rdata, o.mis, o.err, e.rdata, e.mis, e.err); end
      end
    end
  endtask

  task automatic test_errors;
    rsp_t e, o;
    exp_q.push_back('{32'h0, 1'b0, 1'b1});
    run_txn(1'b0, 32'h200, 32'h0, 3'b010, -1, 32'h0, 1'b0);
    n_tests++;
    if (o_req_cycles !== 255 || o_lat !== 256 || o_req_at_done !== 1'b0) begin
      n_fail++; $display("FAIL timeout: req_cycles=%0d lat=%0d bus_req_at_done=%b, required 255 256 0",
                         o_req_cycles, o_lat, o_req_at_done);
    end
    exp_q.push_back('{32'h0, 1'b0, 1'b1});
    run_txn(1'b0, 32'h204, 32'h0, 3'b010, 0, 32'h12345678, 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL error_rsp: no response, required %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL error_rsp: got rdata=%h mis=%b err=%b, required rdata=%h mis=%b err=%b",
                                              o.rdata, o.mis, o.err, e.rdata, e.mis, e.err); end
      end
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    rsp_t e, o;
    req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h300; req_mode_i = 3'b010;
    @(posedge clk); #1;
    bus_gnt_i = bus_req_o;
    @(posedge clk); #1;
    bus_gnt_i = 1'b0; rst = 1'b1; req_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus_req_o !== 1'b0 || rsp_valid_o !== 1'b0 || stall_o !== 1'b0 || bus_err_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid: bus_req=%b rsp_valid=%b stall=%b err=%b, required 0 0 0 0",
                         bus_req_o, rsp_valid_o, stall_o, bus_err_o);
    end
    @(posedge clk); #1;
    bus_rvalid_i = 1'b1; bus_rdata_i = 32'h11111111;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus_rvalid_i = 1'b0;
      @(negedge clk);
      if (rsp_valid_o) seen++;
    end
    n_tests++;
    if (seen !== 0) begin n_fail++; $display("FAIL stale_rvalid: rsp_valid pulses=%0d, required 0", seen); end
    @(posedge clk); #1;
    exp_q.push_back('{32'h0BADF00D, 1'b0, 1'b0});
    run_txn(1'b0, 32'h300, 32'h0, 3'b010, 0, 32'h0BADF00D, 1'b0);
    n_tests++;
    if (o_lat !== 3) begin n_fail++; $display("FAIL post_rst_latency: got %0d, required 3", o_lat); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL post_rst_rsp: no response, required %h", e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin n_fail++; $display("FAIL post_rst_rsp: got %h, required %h", o, e); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_misalign_illegal();
    test_errors();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
